// File: rtl/ram_port_arbiter_pkg.sv
// rtl/ram_port_arbiter_pkg.sv - shared widths and FSM encoding for ram_port_arbiter
// Purpose: default RAM geometry and the arbiter state encoding.
// Ports: none (package).
`timescale 1ns/1ps
package ram_port_arbiter_pkg;

  localparam int DATA_WIDTH_DEF = 3;
  localparam int ADDR_WIDTH_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDWAIT = 2'd2,
    ST_CLEAR  = 2'd3
  } state_t;

  // Channel identifiers as used by the winner / last-granted flags.
  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

endpackage

// File: rtl/ram_port_arbiter_rr_pick2.sv
// rtl/ram_port_arbiter_rr_pick2.sv - two-way round-robin pick
// Purpose: choose between two requesters, favouring the one not granted last.
// Ports: req_a/req_b requests, last = channel granted last (0 = A, 1 = B);
//        winner = picked channel (0 = A, 1 = B), valid = some request present.
`timescale 1ns/1ps
module rr_pick2 (
  input  logic req_a,
  input  logic req_b,
  input  logic last,
  output logic winner,
  output logic valid
);

  assign valid  = req_a | req_b;
  // On a tie the channel that did not win last time goes; otherwise the lone requester.
  assign winner = (req_a & req_b) ? ~last : req_b;

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-channel arbiter for a single-port synchronous RAM
// Purpose: round-robin access of channels A/B to one RAM port plus a whole-RAM clear.
// Ports: clk, rst (async active-low), init (clear pulse);
//        req_*/we_*/addr_*/din_* channel requests; gnt_*/rvalid_*/rdata_* channel responses;
//        busy (clear pending or running);
//        ram_cs/ram_we/ram_oe/ram_addr/ram_din registered RAM controls, ram_dout RAM read data.
`timescale 1ns/1ps
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic                  req_a,
  input  logic                  req_b,
  input  logic                  we_a,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] din_a,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic                  gnt_a,
  output logic                  gnt_b,
  output logic                  rvalid_a,
  output logic                  rvalid_b,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic                  busy,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  state_t state, state_n;
  logic clr_pend, pend_n;
  logic [ADDR_WIDTH-1:0] clr_cnt, cnt_n;
  logic last, last_n;   // channel granted most recently
  logic win, win_n;     // channel owning the current transaction
  logic wr, wr_n;       // current transaction is a write
  logic pick, pick_valid;

  logic gnt_a_n, gnt_b_n, rvalid_a_n, rvalid_b_n, busy_n;
  logic cs_n, we_n, oe_n;
  logic [DATA_WIDTH-1:0] rdata_a_n, rdata_b_n, din_n;
  logic [ADDR_WIDTH-1:0] addr_n;

  rr_pick2 u_pick (
    .req_a  (req_a),
    .req_b  (req_b),
    .last   (last),
    .winner (pick),
    .valid  (pick_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n    = state;
    // An init seen in IDLE is acted on at once so the clear starts the next cycle.
    pend_n     = clr_pend | (init & (state != ST_CLEAR));
    cnt_n      = clr_cnt;
    last_n     = last;
    win_n      = win;
    wr_n       = wr;
    gnt_a_n    = 1'b0;
    gnt_b_n    = 1'b0;
    rvalid_a_n = 1'b0;
    rvalid_b_n = 1'b0;
    rdata_a_n  = rdata_a;
    rdata_b_n  = rdata_b;
    cs_n       = 1'b0;
    we_n       = 1'b0;
    oe_n       = 1'b0;
    addr_n     = ram_addr;
    din_n      = ram_din;
    unique case (state)
      ST_IDLE: begin
        if (pend_n) begin
          state_n = ST_CLEAR;
          pend_n  = 1'b0;
          cnt_n   = '0;
          cs_n    = 1'b1;
          we_n    = 1'b1;
          addr_n  = '0;
          din_n   = '0;
        end else if (pick_valid) begin
          state_n = ST_ACCESS;
          win_n   = pick;
          last_n  = pick;
          wr_n    = (pick == CH_B) ? we_b : we_a;
          addr_n  = (pick == CH_B) ? addr_b : addr_a;
          din_n   = (pick == CH_B) ? din_b : din_a;
          gnt_a_n = (pick == CH_A);
          gnt_b_n = (pick == CH_B);
          cs_n    = 1'b1;
          we_n    = wr_n;
          oe_n    = ~wr_n;
        end
      end
      ST_ACCESS: state_n = wr ? ST_IDLE : ST_RDWAIT;
      ST_RDWAIT: begin
        state_n = ST_IDLE;
        if (win == CH_B) begin
          rdata_b_n  = ram_dout;
          rvalid_b_n = 1'b1;
        end else begin
          rdata_a_n  = ram_dout;
          rvalid_a_n = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt == '1) begin
          state_n = ST_IDLE;
        end else begin
          cnt_n  = clr_cnt + 1'b1;
          addr_n = clr_cnt + 1'b1;
          cs_n   = 1'b1;
          we_n   = 1'b1;
          din_n  = '0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    busy_n = pend_n | (state_n == ST_CLEAR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_pend <= 1'b0;
      clr_cnt  <= '0;
      last     <= CH_B;
      win      <= CH_A;
      wr       <= 1'b0;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
      rdata_a  <= '0;
      rdata_b  <= '0;
      busy     <= 1'b0;
      ram_cs   <= 1'b0;
      ram_we   <= 1'b0;
      ram_oe   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else begin
      clr_pend <= pend_n;
      clr_cnt  <= cnt_n;
      last     <= last_n;
      win      <= win_n;
      wr       <= wr_n;
      gnt_a    <= gnt_a_n;
      gnt_b    <= gnt_b_n;
      rvalid_a <= rvalid_a_n;
      rvalid_b <= rvalid_b_n;
      rdata_a  <= rdata_a_n;
      rdata_b  <= rdata_b_n;
      busy     <= busy_n;
      ram_cs   <= cs_n;
      ram_we   <= we_n;
      ram_oe   <= oe_n;
      ram_addr <= addr_n;
      ram_din  <= din_n;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - self-checking bench for ram_port_arbiter
`timescale 1ns/1ps
module tb_ram_port_arbiter;

  localparam int DW = 3;
  localparam int AW = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic init = 1'b0;
  logic req_a = 1'b0, req_b = 1'b0, we_a = 1'b0, we_b = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] din_a = '0, din_b = '0;
  logic gnt_a, gnt_b, rvalid_a, rvalid_b, busy, ram_cs, ram_we, ram_oe;
  logic [DW-1:0] rdata_a, rdata_b, ram_din;
  logic [DW-1:0] ram_dout = '0;
  logic [AW-1:0] ram_addr;

  ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .init(init),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .din_a(din_a), .din_b(din_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .busy(busy),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM attached to the arbiter.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) ram[ram_addr] <= ram_din;
      if (ram_oe) ram_dout <= ram[ram_addr];
    end
  end

  // Reference model: expected RAM contents, last-granted channel, per-channel request.
  logic [DW-1:0] mem [DEPTH];
  logic exp_last;
  logic op_we [2];
  logic [AW-1:0] op_addr [2];
  logic [DW-1:0] op_din [2];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk(tag, {gnt_a, gnt_b, rvalid_a, rvalid_b, busy, ram_cs, ram_we, ram_oe,
              rdata_a, rdata_b, ram_addr, ram_din}, 32'd0);
  endtask

  task automatic set_req(input logic ch, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    op_we[ch] = we;
    op_addr[ch] = a;
    op_din[ch] = d;
    if (ch) begin
      req_b = 1'b1; we_b = we; addr_b = a; din_b = d;
    end else begin
      req_a = 1'b1; we_a = we; addr_a = a; din_a = d;
    end
  endtask

  task automatic clr_req(input logic ch);
    if (ch) req_b = 1'b0;
    else    req_a = 1'b0;
  endtask

  // Called in the cycle the grant is expected.
  task automatic expect_gnt(input logic ch, input string tag);
    chk({tag, ".gnt"}, {gnt_b, gnt_a}, ch ? 2'b10 : 2'b01);
    chk({tag, ".ctl"}, {ram_cs, ram_we, ram_oe}, {1'b1, op_we[ch], ~op_we[ch]});
    chk({tag, ".addr"}, ram_addr, op_addr[ch]);
    if (op_we[ch]) begin
      chk({tag, ".din"}, ram_din, op_din[ch]);
      mem[op_addr[ch]] = op_din[ch];
    end
    exp_last = ch;
  endtask

  // Completes the granted transaction; returns in an idle cycle.
  task automatic finish_op(input logic ch, input string tag);
    clr_req(ch);
    if (!op_we[ch]) begin
      tick;
      chk({tag, ".rv_early"}, {rvalid_b, rvalid_a}, 2'b00);
      tick;
      chk({tag, ".rvalid"}, {rvalid_b, rvalid_a}, ch ? 2'b10 : 2'b01);
      chk({tag, ".rdata"}, ch ? rdata_b : rdata_a, mem[op_addr[ch]]);
    end else begin
      tick;
      chk({tag, ".cs_off"}, {ram_cs, ram_we, ram_oe}, 3'b000);
    end
  endtask

  task automatic single(input logic ch, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input string tag);
    set_req(ch, we, a, d);
    tick;
    expect_gnt(ch, tag);
    finish_op(ch, tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0; init = 1'b0; req_a = 1'b0; req_b = 1'b0;
    #1;
    chk_reset(tag);
    tick;
    rst = 1'b1;
    exp_last = 1'b1;
  endtask

  initial begin
    logic [3:0] order;
    int got, cyc;
    logic seen;
    logic w, w2, we2;
    logic [AW-1:0] a2;
    logic [DW-1:0] d2;

    // Reset values.
    exp_last = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b1;
    tick;
    chk_reset("after_release");

    // Write on A, then read back on B.
    single(1'b0, 1'b1, 3'd3, 3'd5, "write_a");
    single(1'b1, 1'b0, 3'd3, 3'd0, "read_b");

    // Tie from reset: A, B, A, B.
    do_reset("reset_tie");
    set_req(1'b0, 1'b1, 3'd0, 3'd1);
    set_req(1'b1, 1'b1, 3'd1, 3'd2);
    got = 0; order = '0; cyc = 0;
    while (got < 4 && cyc < 20) begin
      tick;
      cyc++;
      if (gnt_a | gnt_b) begin
        order[got] = gnt_b;
        got++;
      end
    end
    clr_req(1'b0);
    clr_req(1'b1);
    chk("tie.count", got, 4);
    chk("tie.order", order, 4'b1010);
    mem[0] = 3'd1;
    mem[1] = 3'd2;
    exp_last = 1'b1;
    tick;

    // Fill with 7, clear, read back zeros.
    for (int i = 0; i < DEPTH; i++) single(1'b0, 1'b1, AW'(i), 3'd7, "fill");
    init = 1'b1;
    tick;
    init = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      chk("clear.busy", busy, 1);
      chk("clear.addr", ram_addr, i);
      chk("clear.ctl", {ram_cs, ram_we, ram_oe, ram_din}, {3'b110, 3'd0});
      tick;
    end
    chk("clear.done", {busy, ram_cs}, 2'b00);
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    for (int i = 0; i < DEPTH; i++) single(1'($urandom_range(0, 1)), 1'b0, AW'(i), 3'd0, "clear_rd");

    // init during a read: read completes, clear runs, held request served after.
    single(1'b0, 1'b1, 3'd2, 3'd4, "pre_init_wr");
    set_req(1'b0, 1'b0, 3'd2, 3'd0);
    tick;
    expect_gnt(1'b0, "init_rd");
    init = 1'b1;
    clr_req(1'b0);
    tick;
    init = 1'b0;
    chk("init_rd.busy_rdwait", {busy, rvalid_a}, 2'b10);
    tick;
    chk("init_rd.rvalid", {busy, rvalid_a, rvalid_b}, 3'b110);
    chk("init_rd.rdata", rdata_a, 3'd4);
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    set_req(1'b0, 1'b1, 3'd5, 3'd6);
    tick;
    cyc = 0; seen = 1'b0;
    while (busy && cyc < 20) begin
      seen = seen | gnt_a | gnt_b;
      cyc++;
      tick;
    end
    chk("init_rd.clear_len", cyc, 8);
    chk("init_rd.no_gnt_busy", seen, 0);
    chk("init_rd.gnt_idle", gnt_a, 0);
    tick;
    expect_gnt(1'b0, "held_req");
    finish_op(1'b0, "held_req");

    // Reset during CLEAR at address 4.
    for (int i = 0; i < DEPTH; i++) single(1'b1, 1'b1, AW'(i), 3'd7, "fill2");
    init = 1'b1;
    tick;
    init = 1'b0;
    cyc = 0;
    while (ram_addr != 3'd4 && cyc < 20) begin
      tick;
      cyc++;
    end
    chk("rst_clr.at4", ram_addr, 4);
    do_reset("rst_clr.immediate");
    for (int i = 0; i < 4; i++) mem[i] = '0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      seen = seen | ram_cs | busy | gnt_a | gnt_b | rvalid_a | rvalid_b;
    end
    chk("rst_clr.quiet", seen, 0);
    single(1'b0, 1'b0, 3'd3, 3'd0, "rst_clr.rd3");
    single(1'b1, 1'b0, 3'd4, 3'd0, "rst_clr.rd4");
    single(1'b0, 1'b0, 3'd7, 3'd0, "rst_clr.rd7");

    // Randomized single and tied accesses against the model.
    for (int n = 0; n < 60; n++) begin
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) < 2) begin
        single(w, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
               DW'($urandom_range(0, 7)), "rand");
      end else begin
        we2 = 1'($urandom_range(0, 1));
        a2 = AW'($urandom_range(0, DEPTH - 1));
        d2 = DW'($urandom_range(0, 7));
        set_req(1'b0, we2, a2, d2);
        set_req(1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
                DW'($urandom_range(0, 7)));
        w2 = ~exp_last;
        tick;
        expect_gnt(w2, "rtie1");
        finish_op(w2, "rtie1");
        tick;
        expect_gnt(~w2, "rtie2");
        finish_op(~w2, "rtie2");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 3, RAM word width.
REQ-002 Parameter ADDR_WIDTH, default 3, RAM address width; depth = 2**ADDR_WIDTH (8).
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 init  in  1  one-cycle pulse: clear the whole RAM to zero.
REQ-006 req_a, req_b  in  1 each  access request per channel.
REQ-007 we_a, we_b  in  1 each  1 = write, 0 = read; qualified by req.
REQ-008 addr_a, addr_b  in  ADDR_WIDTH each  access address.
REQ-009 din_a, din_b  in  DATA_WIDTH each  write data.
REQ-010 gnt_a, gnt_b  out  1 each  one-cycle grant pulse.
REQ-011 rvalid_a, rvalid_b  out  1 each  one-cycle read-data-valid pulse.
REQ-012 rdata_a, rdata_b  out  DATA_WIDTH each  read data; held until next rvalid of that channel.
REQ-013 busy  out  1  high while clear sequence pending or running.
REQ-014 ram_cs, ram_we, ram_oe  out  1 each  RAM port controls, registered.
REQ-015 ram_addr  out  ADDR_WIDTH; ram_din  out  DATA_WIDTH; ram_dout  in  DATA_WIDTH (synchronous read, valid the cycle after ram_cs & ram_oe).

Function
REQ-016 FSM states SHALL be IDLE, ACCESS, RDWAIT, CLEAR.
REQ-017 IDLE: clear pending -> CLEAR; else any req -> ACCESS with winner's we/addr/din latched; else stay.
REQ-018 Both req high in IDLE: channel not granted last wins (round-robin); single req wins outright.
REQ-019 ACCESS (exactly one cycle): gnt of winner = 1, ram_cs = 1, ram_we = latched we, ram_oe = ~latched we, ram_addr/ram_din = latched values; write -> IDLE, read -> RDWAIT.
REQ-020 RDWAIT (one cycle): capture ram_dout into winner's rdata; next cycle rvalid of winner = 1 and FSM in IDLE.
REQ-021 Latency: req sampled in IDLE at cycle N -> gnt at N+1; read rvalid at N+3; write completes at N+1.
REQ-022 Requester SHALL hold req/we/addr/din until gnt seen; req still high in the IDLE cycle after gnt is a new request.
REQ-023 At most one of gnt_a, gnt_b high in any cycle; same for rvalid_a, rvalid_b.
REQ-024 init sampled high in any state sets clear-pending; busy = 1 from the following cycle; pending request/transaction in flight completes first.
REQ-025 CLEAR: ram_cs = 1, ram_we = 1, ram_oe = 0, ram_din = 0, ram_addr counts 0..depth-1, one address per cycle; after last address -> IDLE, busy = 0 same cycle.
REQ-026 init during CLEAR SHALL be ignored; requests during CLEAR are held off (no gnt) and served afterwards per REQ-018.
REQ-027 Outside ACCESS and CLEAR, ram_cs, ram_we, ram_oe = 0; ram_addr, ram_din hold last value.

Reset
REQ-028 rst = 0 SHALL immediately force IDLE, clear-pending 0, clear counter 0, last-granted = B (so A wins first tie).
REQ-029 Reset values: gnt_*, rvalid_*, busy, ram_cs, ram_we, ram_oe = 0; rdata_*, ram_addr, ram_din = 0.
REQ-030 Reset mid-transaction or mid-CLEAR SHALL abort it; no gnt/rvalid issued for it after release.

Structure
REQ-031 Shared package SHALL hold DATA_WIDTH/ADDR_WIDTH defaults and FSM state encoding constants.
REQ-032 Round-robin select SHALL be one sub-module rr_pick2 (inputs req_a, req_b, last; outputs winner, valid); rest flat.

Verification
REQ-033 Write A: req_a, we_a=1, addr_a=3, din_a=5 -> gnt_a next cycle with ram_cs=1, ram_we=1, ram_addr=3, ram_din=5.
REQ-034 Read back: req_b, we_b=0, addr_b=3 after REQ-033 -> gnt_b at N+1, rvalid_b at N+3, rdata_b=5.
REQ-035 Tie: req_a and req_b held high for 4 grants -> gnt order A, B, A, B from reset.
REQ-036 Clear: write 7 at all addresses, pulse init -> busy 1 for 8 cycles, ram_addr 0..7 with ram_din=0; subsequent reads return 0.
REQ-037 init pulsed during a read -> rvalid still delivered, then CLEAR; req_a during CLEAR gets gnt only after busy falls.
REQ-038 rst low during CLEAR at address 4 -> all outputs at reset values immediately, no further writes after release.
